// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared definitions for the fetch/decode sequencing controller:
// next-PC select codes, controller states, the bubble word and the
// RV32I opcodes the controller has to recognise.
package fetch_hazard_ctrl_pkg;

  // Next-PC mux select encodings
  localparam logic [1:0] PC_SEL_PC4    = 2'd0;
  localparam logic [1:0] PC_SEL_HOLD   = 2'd1;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd2;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd3;

  // Controller states: normal issue, branch resolving in execute,
  // jump resolving in execute
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_WAIT  = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // addi x0,x0,0 -- the word issued whenever a bubble is needed
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // RV32I major opcodes relevant to sequencing
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;

  // An instruction writes the register file unless it is a branch or a
  // store, and writes to x0 are discarded so they never create a hazard.
  function automatic logic is_writer(input logic [6:0] opc, input logic [4:0] rd);
    return (opc != OPC_BRANCH) && (opc != OPC_STORE) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Fetch-side bus between the pipeline and the sequencing controller.
// Names carry the direction as seen from the controller.
interface fetch_hazard_ctrl_if;

  logic [31:0] i_icache_dout;
  logic        i_stall;
  logic        i_br_taken;
  logic [31:0] o_issued_inst;
  logic        o_nop_sel;
  logic [1:0]  o_pc_sel;

  // Pipeline side: supplies the fetched word and execute feedback
  modport master (
    output i_icache_dout,
    output i_stall,
    output i_br_taken,
    input  o_issued_inst,
    input  o_nop_sel,
    input  o_pc_sel
  );

  // Controller side
  modport slave (
    input  i_icache_dout,
    input  i_stall,
    input  i_br_taken,
    output o_issued_inst,
    output o_nop_sel,
    output o_pc_sel
  );

endinterface

// File: rtl/fetch_hazard_ctrl_hazard_detect.sv
// Combinational classification of the fetched word against the word
// currently in decode/execute: control-transfer type and the JALR
// read-after-write interlock.
module hazard_detect
  import fetch_hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_icache_dout,
  input  logic [31:0] i_issued_inst,
  output logic        o_is_branch,
  output logic        o_is_jump,
  output logic        o_jalr_raw
);

  logic [6:0] w_fetch_opc;
  logic [4:0] w_fetch_rs1;
  logic [6:0] w_issued_opc;
  logic [4:0] w_issued_rd;
  logic       w_fetch_is_jalr;
  logic       w_unused_bits;

  assign w_fetch_opc  = i_icache_dout[6:0];
  assign w_fetch_rs1  = i_icache_dout[19:15];
  assign w_issued_opc = i_issued_inst[6:0];
  assign w_issued_rd  = i_issued_inst[11:7];

  assign w_fetch_is_jalr = (w_fetch_opc == OPC_JALR);

  assign o_is_branch = (w_fetch_opc == OPC_BRANCH);
  assign o_is_jump   = (w_fetch_opc == OPC_JAL) || w_fetch_is_jalr;

  // The JALR target would be computed from a register the instruction
  // ahead of it has not yet written back.
  assign o_jalr_raw = w_fetch_is_jalr
                   && is_writer(w_issued_opc, w_issued_rd)
                   && (w_issued_rd == w_fetch_rs1);

  // Fields that play no part in sequencing decisions
  assign w_unused_bits = ^{i_icache_dout[31:20], i_icache_dout[14:7], i_issued_inst[31:12]};

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch/decode sequencing controller for the 3-stage RV32I pipeline.
// Owns the issued-instruction register, chooses between the icache word
// and a bubble, drives the next-PC select and keeps saturating
// bubble/branch/taken performance counters.
module fetch_hazard_ctrl #(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] NOP_INST = fetch_hazard_ctrl_pkg::NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_hazard_ctrl_if.slave   bus,
  output logic [CNT_W-1:0]     o_bubble_cnt,
  output logic [CNT_W-1:0]     o_branch_cnt,
  output logic [CNT_W-1:0]     o_taken_cnt
);

  import fetch_hazard_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_issued_inst;
  logic [CNT_W-1:0]   r_bubble_cnt;
  logic [CNT_W-1:0]   r_branch_cnt;
  logic [CNT_W-1:0]   r_taken_cnt;

  logic               w_nop_sel;
  logic [1:0]         w_pc_sel;
  logic [31:0]        w_issue_word;
  logic               w_is_branch;
  logic               w_is_jump;
  logic               w_jalr_raw;

  hazard_detect u_hazard_detect (
    .i_icache_dout (bus.i_icache_dout),
    .i_issued_inst (r_issued_inst),
    .o_is_branch   (w_is_branch),
    .o_is_jump     (w_is_jump),
    .o_jalr_raw    (w_jalr_raw)
  );

  // Per-cycle issue decision and next state; stall and reset override
  // only the PC select (and, for reset, the bubble select).
  always_comb begin
    w_nop_sel    = 1'b0;
    w_pc_sel     = PC_SEL_PC4;
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_jalr_raw) begin
          w_nop_sel = 1'b1;
          w_pc_sel  = PC_SEL_HOLD;
        end else if (w_is_branch) begin
          w_state_next = ST_BR_WAIT;
        end else if (w_is_jump) begin
          w_state_next = ST_REDIRECT;
        end
      end
      ST_BR_WAIT: begin
        w_nop_sel    = 1'b1;
        w_pc_sel     = bus.i_br_taken ? PC_SEL_BRANCH : PC_SEL_PC4;
        w_state_next = ST_RUN;
      end
      ST_REDIRECT: begin
        w_nop_sel    = 1'b1;
        w_pc_sel     = PC_SEL_JUMP;
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
    if (bus.i_stall) begin
      w_pc_sel = PC_SEL_HOLD;
    end
    if (rst) begin
      w_nop_sel = 1'b1;
      w_pc_sel  = PC_SEL_HOLD;
    end
  end

  assign w_issue_word = w_nop_sel ? NOP_INST : bus.i_icache_dout;

  // State, issue register and counters advance together; a stall freezes all of them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_issued_inst <= NOP_INST;
      r_bubble_cnt  <= '0;
      r_branch_cnt  <= '0;
      r_taken_cnt   <= '0;
    end else if (!bus.i_stall) begin
      r_state       <= w_state_next;
      r_issued_inst <= w_issue_word;
      if (w_nop_sel && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
      if (r_state == ST_BR_WAIT) begin
        if (r_branch_cnt != CNT_MAX) begin
          r_branch_cnt <= r_branch_cnt + CNT_ONE;
        end
        if (bus.i_br_taken && (r_taken_cnt != CNT_MAX)) begin
          r_taken_cnt <= r_taken_cnt + CNT_ONE;
        end
      end
    end
  end

  assign bus.o_issued_inst = r_issued_inst;
  assign bus.o_nop_sel     = w_nop_sel;
  assign bus.o_pc_sel      = w_pc_sel;
  assign o_bubble_cnt      = r_bubble_cnt;
  assign o_branch_cnt      = r_branch_cnt;
  assign o_taken_cnt       = r_taken_cnt;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: a full-width instance and a 4-bit-counter
// instance share the same stimulus; a pipeline-level reference model
// predicts every output.
module tb_fetch_hazard_ctrl;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] ADDI_X0_5  = 32'h0050_0013;
  localparam logic [31:0] ADDI_X5_64 = 32'h0400_0293;
  localparam logic [31:0] JALR_X5    = 32'h0002_8067;
  localparam logic [31:0] SW_X5      = 32'h0051_2023;
  localparam logic [31:0] BEQ        = 32'h0000_0463;
  localparam logic [31:0] JAL_X1     = 32'h0000_00EF;
  localparam logic [6:0]  OP_BRANCH  = 7'b110_0011;
  localparam logic [6:0]  OP_STORE   = 7'b010_0011;
  localparam logic [6:0]  OP_JAL     = 7'b110_1111;
  localparam logic [6:0]  OP_JALR    = 7'b110_0111;
  localparam logic [6:0]  OP_IMM     = 7'b001_0011;
  localparam logic [6:0]  OP_LOAD    = 7'b000_0011;
  localparam logic [6:0]  OP_REG     = 7'b011_0011;

  logic clk;
  logic rst;
  logic [31:0] bigBubble, bigBranch, bigTaken;
  logic [3:0]  smallBubble, smallBranch, smallTaken;

  fetch_hazard_ctrl_if busA ();
  fetch_hazard_ctrl_if busB ();

  fetch_hazard_ctrl #(.CNT_W(32)) dutBig (
    .clk          (clk),
    .rst          (rst),
    .bus          (busA),
    .o_bubble_cnt (bigBubble),
    .o_branch_cnt (bigBranch),
    .o_taken_cnt  (bigTaken)
  );

  fetch_hazard_ctrl #(.CNT_W(4)) dutSmall (
    .clk          (clk),
    .rst          (rst),
    .bus          (busB),
    .o_bubble_cnt (smallBubble),
    .o_branch_cnt (smallBranch),
    .o_taken_cnt  (smallTaken)
  );

  assign busB.i_icache_dout = busA.i_icache_dout;
  assign busB.i_stall       = busA.i_stall;
  assign busB.i_br_taken    = busA.i_br_taken;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: what sits in execute, plus event tallies
  logic [31:0] mIssued;
  longint      mBubble, mBranch, mTaken;
  logic        expNop;
  logic [1:0]  expPc;
  logic        curRst, curStall, curTaken;
  logic [31:0] curFetch;

  function automatic logic isWriter(input logic [31:0] w);
    return (w[6:0] != OP_BRANCH) && (w[6:0] != OP_STORE) && (w[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] sat4(input longint x);
    return (x > 15) ? 32'd15 : x[31:0];
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and check the combinational select outputs
  task automatic applyStimulus(input logic [31:0] fetch, input logic stall,
                               input logic taken, input logic r);
    @(negedge clk);
    busA.i_icache_dout = fetch;
    busA.i_stall       = stall;
    busA.i_br_taken    = taken;
    rst                = r;
    curFetch = fetch; curStall = stall; curTaken = taken; curRst = r;
    #1;
    if (r) begin
      expNop = 1'b1; expPc = 2'd1;
    end else begin
      if (mIssued[6:0] == OP_BRANCH) begin
        expNop = 1'b1; expPc = taken ? 2'd2 : 2'd0;
      end else if (mIssued[6:0] == OP_JAL || mIssued[6:0] == OP_JALR) begin
        expNop = 1'b1; expPc = 2'd3;
      end else if (fetch[6:0] == OP_JALR && isWriter(mIssued) && mIssued[11:7] == fetch[19:15]) begin
        expNop = 1'b1; expPc = 2'd1;
      end else begin
        expNop = 1'b0; expPc = 2'd0;
      end
      if (stall) expPc = 2'd1;
    end
    checkVal("nop_sel", {31'd0, busA.o_nop_sel}, {31'd0, expNop});
    checkVal("pc_sel", {30'd0, busA.o_pc_sel}, {30'd0, expPc});
    checkVal("nop_sel_small", {31'd0, busB.o_nop_sel}, {31'd0, expNop});
  endtask

  // Advance the model across the clock edge and check registered outputs
  task automatic checkOutput();
    @(posedge clk);
    #1;
    if (curRst) begin
      mIssued = NOP; mBubble = 0; mBranch = 0; mTaken = 0;
    end else if (!curStall) begin
      if (mIssued[6:0] == OP_BRANCH) begin
        mBranch++;
        if (curTaken) mTaken++;
      end
      if (expNop) mBubble++;
      mIssued = expNop ? NOP : curFetch;
    end
    checkVal("issued_inst", busA.o_issued_inst, mIssued);
    checkVal("bubble_cnt", bigBubble, mBubble[31:0]);
    checkVal("branch_cnt", bigBranch, mBranch[31:0]);
    checkVal("taken_cnt", bigTaken, mTaken[31:0]);
    checkVal("issued_inst_small", busB.o_issued_inst, mIssued);
    checkVal("bubble_cnt_small", {28'd0, smallBubble}, sat4(mBubble));
    checkVal("branch_cnt_small", {28'd0, smallBranch}, sat4(mBranch));
    checkVal("taken_cnt_small", {28'd0, smallTaken}, sat4(mTaken));
  endtask

  task automatic step(input logic [31:0] fetch, input logic stall, input logic taken, input logic r);
    applyStimulus(fetch, stall, taken, r);
    checkOutput();
  endtask

  // Guard against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    int kind;
    mIssued = NOP; mBubble = 0; mBranch = 0; mTaken = 0;
    rst = 1'b1;
    busA.i_icache_dout = ADDI_X1_5;
    busA.i_stall = 1'b0;
    busA.i_br_taken = 1'b0;

    // Reset then idle
    $display("[TB] reset then idle");
    repeat (3) step(ADDI_X1_5, 1'b0, 1'b0, 1'b1);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    checkVal("idle_issued", busA.o_issued_inst, ADDI_X1_5);
    checkVal("idle_bubbles", bigBubble, 32'd0);

    // Branch not taken, then taken
    $display("[TB] branches");
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b1);
    step(BEQ, 1'b0, 1'b0, 1'b0);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    step(BEQ, 1'b0, 1'b0, 1'b0);
    step(ADDI_X1_5, 1'b0, 1'b1, 1'b0);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    checkVal("br_branch_cnt", bigBranch, 32'd2);
    checkVal("br_taken_cnt", bigTaken, 32'd1);
    checkVal("br_bubble_cnt", bigBubble, 32'd2);

    // Dependent JALR: interlock bubble plus redirect bubble
    $display("[TB] jalr raw");
    step(NOP, 1'b0, 1'b0, 1'b1);
    step(ADDI_X5_64, 1'b0, 1'b0, 1'b0);
    step(JALR_X5, 1'b0, 1'b0, 1'b0);
    step(JALR_X5, 1'b0, 1'b0, 1'b0);
    checkVal("raw_jalr_issued", busA.o_issued_inst, JALR_X5);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    checkVal("raw_bubble_cnt", bigBubble, 32'd2);

    // JALR behind a store and behind an x0 writer: no interlock
    $display("[TB] jalr no hazard");
    step(NOP, 1'b0, 1'b0, 1'b1);
    step(SW_X5, 1'b0, 1'b0, 1'b0);
    step(JALR_X5, 1'b0, 1'b0, 1'b0);
    checkVal("nohaz_jalr_issued", busA.o_issued_inst, JALR_X5);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    step(ADDI_X0_5, 1'b0, 1'b0, 1'b0);
    step(JALR_X5, 1'b0, 1'b0, 1'b0);
    checkVal("nohaz_x0_jalr_issued", busA.o_issued_inst, JALR_X5);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    checkVal("nohaz_bubble_cnt", bigBubble, 32'd2);

    // Stall while a branch is resolving
    $display("[TB] stall mid-branch");
    step(NOP, 1'b0, 1'b0, 1'b1);
    step(BEQ, 1'b0, 1'b0, 1'b0);
    repeat (4) step(ADDI_X1_5, 1'b1, 1'b1, 1'b0);
    checkVal("stall_issued", busA.o_issued_inst, BEQ);
    checkVal("stall_branch_cnt", bigBranch, 32'd0);
    step(ADDI_X1_5, 1'b0, 1'b1, 1'b0);
    checkVal("stall_branch_after", bigBranch, 32'd1);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);

    // Reset while a jump is redirecting
    $display("[TB] reset mid-redirect");
    step(JAL_X1, 1'b0, 1'b0, 1'b0);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b1);
    checkVal("rst_redirect_issued", busA.o_issued_inst, NOP);
    step(ADDI_X1_5, 1'b0, 1'b0, 1'b0);
    checkVal("rst_redirect_run", busA.o_issued_inst, ADDI_X1_5);

    // Back-to-back jumps: 20 bubbles saturate the 4-bit counter
    $display("[TB] saturation");
    step(NOP, 1'b0, 1'b0, 1'b1);
    repeat (40) step(JAL_X1, 1'b0, 1'b0, 1'b0);
    checkVal("sat_big_bubble", bigBubble, 32'd20);
    checkVal("sat_small_bubble", {28'd0, smallBubble}, 32'd15);

    // Randomized instruction stream with stalls and occasional resets
    $display("[TB] random stream");
    step(NOP, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      kind = $urandom_range(0, 9);
      case (kind)
        0:       w[6:0] = OP_BRANCH;
        1:       w[6:0] = OP_STORE;
        2:       w[6:0] = OP_JAL;
        3, 4:    w[6:0] = OP_JALR;
        5, 6:    w[6:0] = OP_IMM;
        7:       w[6:0] = OP_LOAD;
        8:       w[6:0] = OP_REG;
        default: w[6:0] = w[6:0];
      endcase
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      step(w, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
Sequencing controller for the fetch/decode boundary of the 3-stage RV32I pipeline. It owns the issued-instruction register that feeds decode/execute, and it decides each cycle whether the icache word or a NOP bubble is issued. It drives the PC-select mux for branch resolution, JAL/JALR redirects and JALR read-after-write interlocks. It also exports bubble and branch counters for the CSR performance view.

Parameters:
CNT_W, 32, width of the performance counters (saturating)
NOP_INST, 32'h0000_0013, encoding injected as a bubble (addi x0,x0,0)

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
icache_dout  input  32  instruction word fetched this cycle
stall  input  1  cache stall; freezes all controller state
br_taken  input  1  branch comparator result; valid only while state==BR_WAIT
issued_inst  output  32  registered instruction presented to decode/execute
nop_sel  output  1  1: NOP_INST issued this cycle instead of icache_dout
pc_sel  output  2  next-PC select: 0 PC4, 1 HOLD, 2 BRANCH target, 3 JUMP target
bubble_cnt  output  CNT_W  bubbles inserted since reset
branch_cnt  output  CNT_W  branches resolved since reset
taken_cnt  output  CNT_W  branches resolved taken since reset

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Issue path:
  - issue_word = nop_sel ? NOP_INST : icache_dout.
  - issued_inst <= issue_word on clk when !stall && !rst.
- Hazard definition:
  - Writer instruction = opcode not in {BRANCH, STORE} and rd != 0.
  - jalr_raw = icache_dout is JALR && issued_inst is a writer && issued_inst.rd == icache_dout.rs1.
- FSM states: RUN, BR_WAIT, REDIRECT.
- RUN:
  - If jalr_raw: nop_sel=1, pc_sel=HOLD (refetch the JALR), stay RUN.
  - Else if icache_dout is BRANCH: nop_sel=0, pc_sel=PC4, next BR_WAIT.
  - Else if icache_dout is JAL or JALR: nop_sel=0, pc_sel=PC4, next REDIRECT.
  - Else: nop_sel=0, pc_sel=PC4.
- BR_WAIT (branch in execute): nop_sel=1 (squash wrong-path word), pc_sel = br_taken ? BRANCH : PC4, next RUN.
- REDIRECT (jump in execute): nop_sel=1, pc_sel=JUMP, next RUN.
- Stall, highest priority over everything except rst:
  - pc_sel=HOLD.
  - State, issued_inst and counters hold.
  - nop_sel keeps its state-derived value; it has no side effects.
- Reset, also when asserted mid-sequence:
  - state=RUN, issued_inst=NOP_INST, all counters 0.
  - While rst is high: nop_sel=1, pc_sel=HOLD.
  - A pending branch or redirect is discarded.
- Counters:
  - bubble_cnt += 1 on every non-stalled cycle with nop_sel=1 (not during rst).
  - branch_cnt += 1 on each non-stalled BR_WAIT cycle; taken_cnt += 1 on the same cycle if br_taken.
  - All counters saturate at 2^CNT_W-1; no wrap.
- Latency:
  - Branch costs exactly 1 bubble, taken or not.
  - JAL/JALR costs 1 bubble.
  - A JALR hazard adds 1 more bubble, so a dependent JALR costs 2 bubbles total.
- Back-to-back control transfers:
  - The word fetched in BR_WAIT or REDIRECT is always squashed, so it is never evaluated for hazards or state transitions.
  - The first word at the target is evaluated normally in RUN.

Decomposition:
- Shared package/header (alongside the opcode definitions):
  - PC_SEL_PC4/HOLD/BRANCH/JUMP encodings
  - FSM state encodings
  - NOP_INST constant
  - OPC_* opcodes
- Sub-module hazard_detect: purely combinational.
  - Inputs: icache_dout, issued_inst.
  - Outputs: is_branch, is_jump, jalr_raw.
- The FSM, issue register and counters stay in fetch_hazard_ctrl.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst 3 cycles, release, feed addi x1,x0,5 (32'h0050_0093).
  - Response: during rst nop_sel=1, pc_sel=1. Next cycle issued_inst=32'h0050_0093, pc_sel=0, all counters 0.
- Branch not taken then taken:
  - Stimulus: beq (32'h0000_0463), then br_taken=0; later beq again with br_taken=1.
  - Response: BR_WAIT cycle nop_sel=1 with pc_sel=0, then pc_sel=2. branch_cnt=2, taken_cnt=1, bubble_cnt=2.
- JALR RAW:
  - Stimulus: addi x5,x0,64 issued, then fetch jalr x0,0(x5).
  - Response: cycle 1 nop_sel=1 and pc_sel=1. Cycle 2 JALR issued. Cycle 3 nop_sel=1 and pc_sel=3. bubble_cnt=2.
- JALR without hazard:
  - Stimulus: sw x5,0(x2) or an rd=x0 writer, then jalr x0,0(x5).
  - Response: JALR issues immediately, 1 bubble only.
- Stall mid-branch:
  - Stimulus: assert stall 4 cycles while in BR_WAIT.
  - Response: pc_sel=1 and issued_inst unchanged throughout, counters frozen. On release, BR_WAIT resolves once (branch_cnt +1).
- Reset mid-redirect plus saturation:
  - Stimulus: rst in REDIRECT; separately, CNT_W=4 with 20 bubbles.
  - Response: state returns to RUN with issued_inst=32'h0000_0013. bubble_cnt stops at 15.
